dmem_req_ctrl: RTL and testbench

Data-memory request controller between the out-of-order core's load/store unit and the data memory port. It accepts tagged load/store requests through a valid/ready handshake and buffers them in order in a small FIFO. It issues them one at a time to memory using the level-held read/write strobe and `done` protocol, then returns a tagged one-cycle response per request. It replaces direct LSU-to-memory wiring so that the LSU never stalls on memory latency until the queue is full.

---
 rtl/dmem_req_ctrl_pkg.sv | 21 ++
 rtl/dmem_req_ctrl_fifo.sv | 53 +++++
 rtl/dmem_req_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmem_req_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_req_ctrl_pkg.sv
// rtl/dmem_req_ctrl_pkg.sv - shared data types for the data-memory request path
package data_types;

    typedef logic [31:0] word32_t;

    // The queued tag field is sized for the widest LSU tag; narrower tags are zero-extended.
    localparam int DMEM_TAG_W_MAX = 16;

    typedef struct packed {
        logic                      write;
        word32_t                   addr;
        word32_t                   data;
        logic [DMEM_TAG_W_MAX-1:0] tag;
    } dmem_req_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmem_ctrl_state_e;

endpackage

// File: rtl/dmem_req_ctrl_fifo.sv
// rtl/dmem_req_ctrl_fifo.sv - in-order request FIFO with registered storage
module req_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty_o = (r_count == '0);

endmodule

// File: rtl/dmem_req_ctrl.sv
// rtl/dmem_req_ctrl.sv - queues LSU load/store requests and issues them one at a time to data memory
module dmem_req_ctrl
    import data_types::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  word32_t          req_addr_i,
    input  word32_t          req_data_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    output logic             resp_write_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output word32_t          resp_data_o,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output word32_t          dmem_addr_o,
    output word32_t          dmem_data_o,
    input  word32_t          dmem_rd_data_i,
    input  logic             dmem_done_i
);

    dmem_ctrl_state_e r_state;
    dmem_ctrl_state_e w_state_nxt;

    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    logic      w_complete;
    dmem_req_t w_push_data;
    dmem_req_t w_head;
    logic      w_unused_tag;

    logic             r_rd;
    logic             r_wr;
    word32_t          r_addr;
    word32_t          r_wdata;
    logic [TAG_W-1:0] r_tag;

    logic             r_resp_valid;
    logic             r_resp_write;
    logic [TAG_W-1:0] r_resp_tag;
    word32_t          r_resp_data;

    assign w_push = req_valid_i & ~w_full;

    always_comb begin
        w_push_data                = '0;
        w_push_data.write          = req_write_i;
        w_push_data.addr           = req_addr_i;
        w_push_data.data           = req_data_i;
        w_push_data.tag[TAG_W-1:0] = req_tag_i;
    end

    req_fifo #(
        .DEPTH (DEPTH),
        .T     (dmem_req_t)
    ) u_req_fifo (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign w_unused_tag = ^w_head.tag;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // done is only honoured in WAIT, so a stray pulse in IDLE has no effect.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (dmem_done_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_tag        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_resp_tag   <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= w_complete;
            r_resp_write <= w_complete & r_wr;
            r_resp_tag   <= w_complete ? r_tag : '0;
            r_resp_data  <= (w_complete & r_rd) ? dmem_rd_data_i : '0;
            if (w_pop) begin
                r_rd    <= ~w_head.write;
                r_wr    <= w_head.write;
                r_addr  <= w_head.addr;
                r_wdata <= w_head.data;
                r_tag   <= w_head.tag[TAG_W-1:0];
            end else if (w_complete) begin
                r_rd <= 1'b0;
                r_wr <= 1'b0;
            end
        end
    end

    assign req_ready_o  = ~w_full;
    assign resp_valid_o = r_resp_valid;
    assign resp_write_o = r_resp_write;
    assign resp_tag_o   = r_resp_tag;
    assign resp_data_o  = r_resp_data;
    assign dmem_read_o  = r_rd;
    assign dmem_write_o = r_wr;
    assign dmem_addr_o  = r_addr;
    assign dmem_data_o  = r_wdata;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb/tb_dmem_req_ctrl.sv - randomized self-checking bench for dmem_req_ctrl
`timescale 1ns/1ps
module tb_dmem_req_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk_i = 1'b0;
    logic             reset_ni = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic             req_write_i = 1'b0;
    logic [31:0]      req_addr_i = '0;
    logic [31:0]      req_data_i = '0;
    logic [TAG_W-1:0] req_tag_i = '0;
    logic             resp_valid_o;
    logic             resp_write_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic [31:0]      resp_data_o;
    logic             dmem_read_o;
    logic             dmem_write_o;
    logic [31:0]      dmem_addr_o;
    logic [31:0]      dmem_data_o;
    logic [31:0]      dmem_rd_data_i = '0;
    logic             dmem_done_i = 1'b0;

    always #5 clk_i = ~clk_i;

    dmem_req_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_write_i    (req_write_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_tag_i      (req_tag_i),
        .resp_valid_o   (resp_valid_o),
        .resp_write_o   (resp_write_o),
        .resp_tag_o     (resp_tag_o),
        .resp_data_o    (resp_data_o),
        .dmem_read_o    (dmem_read_o),
        .dmem_write_o   (dmem_write_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_data_o    (dmem_data_o),
        .dmem_rd_data_i (dmem_rd_data_i),
        .dmem_done_i    (dmem_done_i)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        bit               write;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [31:0]      rdata;
    } exp_t;

    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    exp_t        iss_q [$];
    exp_t        rsp_q [$];

    int          cyc = 0;
    int          n_acc = 0;
    int          n_issue = 0;
    int          n_resp = 0;
    int          acc_cyc = 0;
    int          resp_cyc = 0;
    int          strobe_len = 0;
    int          last_strobe_len = 0;
    logic [31:0] last_resp_data = '0;
    logic [TAG_W-1:0] last_resp_tag = '0;
    bit          prev_strobe = 0;
    bit          prev_resp = 0;
    bit          expect_rise = 0;
    bit          saw_full = 0;
    exp_t        cur;

    int lat_cfg = 3;
    bit spur = 0;
    bit mem_active = 0;
    int mem_cnt = 0;

    always @(posedge clk_i) cyc++;

    // Memory device: done pulses after the configured number of strobe-high cycles.
    always @(posedge clk_i) begin
        #1;
        dmem_done_i    = 1'b0;
        dmem_rd_data_i = $urandom;
        if (!reset_ni) begin
            mem_active = 0;
        end else begin
            if ((dmem_read_o || dmem_write_o) && !mem_active) begin
                mem_active = 1;
                mem_cnt    = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 5));
            end
            if (mem_active) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    dmem_done_i = 1'b1;
                    mem_active  = 0;
                    if (dmem_write_o) dev_mem[dmem_addr_o] = dmem_data_o;
                    else dmem_rd_data_i = dev_mem.exists(dmem_addr_o) ? dev_mem[dmem_addr_o] : init_word(dmem_addr_o);
                end
            end else if (spur) begin
                dmem_done_i = 1'b1;
            end
        end
    end

    // Reference model: FIFO order in, same order out to memory and back as responses.
    always @(negedge clk_i) begin
        exp_t e;
        bit   strobe;
        if (!reset_ni) begin
            iss_q.delete();
            rsp_q.delete();
            n_acc       = 0;
            n_issue     = 0;
            prev_strobe = 0;
            prev_resp   = 0;
            expect_rise = 0;
            strobe_len  = 0;
        end else begin
            strobe = dmem_read_o | dmem_write_o;
            check("strobe_excl", dmem_read_o & dmem_write_o, 0);
            if (expect_rise) begin
                check("b2b_next_strobe", strobe, 1);
                expect_rise = 0;
            end
            if (strobe && !prev_strobe) begin
                strobe_len = 0;
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", 1, 0);
                end else begin
                    cur = iss_q.pop_front();
                    n_issue++;
                    check("issue_write", dmem_write_o, cur.write);
                    check("issue_addr", dmem_addr_o, cur.addr);
                    if (cur.write) check("issue_data", dmem_data_o, cur.data);
                end
            end else if (strobe) begin
                check("hold_addr", dmem_addr_o, cur.addr);
                check("hold_write", dmem_write_o, cur.write);
            end
            if (strobe) strobe_len++;
            if (!strobe && prev_strobe) last_strobe_len = strobe_len;
            if (resp_valid_o) begin
                check("resp_pulse", prev_resp, 0);
                if (rsp_q.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    e = rsp_q.pop_front();
                    check("resp_tag", resp_tag_o, e.tag);
                    check("resp_write", resp_write_o, e.write);
                    check("resp_data", resp_data_o, e.write ? 32'h0 : e.rdata);
                end
                n_resp++;
                resp_cyc       = cyc;
                last_resp_data = resp_data_o;
                last_resp_tag  = resp_tag_o;
                if (n_acc > n_issue) expect_rise = 1;
            end
            check("ready", req_ready_o, (n_acc - n_issue) < DEPTH);
            if (!req_ready_o) saw_full = 1;
            if (req_valid_i && req_ready_o) begin
                e.write = req_write_i;
                e.addr  = req_addr_i;
                e.data  = req_data_i;
                e.tag   = req_tag_i;
                e.rdata = ref_mem.exists(req_addr_i) ? ref_mem[req_addr_i] : init_word(req_addr_i);
                if (req_write_i) ref_mem[req_addr_i] = req_data_i;
                iss_q.push_back(e);
                rsp_q.push_back(e);
                n_acc++;
                acc_cyc = cyc;
            end
            prev_strobe = strobe;
            prev_resp   = resp_valid_o;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [TAG_W-1:0] t);
        int k = 0;
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_data_i  = d;
        req_tag_i   = t;
        while (1) begin
            @(negedge clk_i);
            if (req_ready_o) break;
            k++;
            if (k > 1000) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_data_i  = $urandom;
    endtask

    task automatic drain();
        int k = 0;
        while (rsp_q.size() != 0 || dmem_read_o || dmem_write_o) begin
            step(1);
            k++;
            if (k > 3000) begin
                check("drain_timeout", 0, 1);
                break;
            end
        end
        step(2);
    endtask

    initial begin
        int r0;
        int k;
        bit w;
        reset_ni = 1'b0;
        step(3);
        check("rst_ready", req_ready_o, 1);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_resp_write", resp_write_o, 0);
        check("rst_resp_tag", resp_tag_o, 0);
        check("rst_resp_data", resp_data_o, 0);
        check("rst_dmem_read", dmem_read_o, 0);
        check("rst_dmem_write", dmem_write_o, 0);
        check("rst_dmem_addr", dmem_addr_o, 0);
        check("rst_dmem_data", dmem_data_o, 0);
        reset_ni = 1'b1;
        step(2);

        // single load, latency 4
        dev_mem[32'h40] = 32'hDEAD_BEEF;
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        lat_cfg = 4;
        send(0, 32'h40, 32'h0, 4'd3);
        drain();
        check("t1_latency", resp_cyc - acc_cyc, 6);
        check("t1_strobe_len", last_strobe_len, 4);
        check("t1_data", last_resp_data, 32'hDEAD_BEEF);
        check("t1_tag", last_resp_tag, 3);

        // store then load of the same word
        lat_cfg = 2;
        send(1, 32'h80, 32'h1234_5678, 4'd5);
        send(0, 32'h80, 32'h0, 4'd6);
        drain();
        check("t2_data", last_resp_data, 32'h1234_5678);
        check("t2_tag", last_resp_tag, 6);

        // back-to-back burst overfills the queue
        lat_cfg  = 5;
        saw_full = 0;
        r0       = n_resp;
        for (int i = 0; i < 6; i++) send(i[0], 32'h100 + 32'(i * 4), $urandom, 4'(8 + i));
        drain();
        check("t3_full_seen", saw_full, 1);
        check("t3_resp_count", n_resp - r0, 6);

        // stray done while idle
        r0  = n_resp;
        spur = 1;
        step(1);
        spur = 0;
        step(3);
        check("t4_no_resp", n_resp - r0, 0);
        check("t4_ready", req_ready_o, 1);
        check("t4_strobes", dmem_read_o | dmem_write_o, 0);
        lat_cfg = 1;
        send(0, 32'h40, 32'h0, 4'd2);
        drain();
        check("t4_after_resp", n_resp - r0, 1);
        check("t4_after_data", last_resp_data, 32'hDEAD_BEEF);

        // reset while waiting on memory
        lat_cfg = 10;
        send(0, 32'h44, 32'h0, 4'd7);
        k = 0;
        while (!dmem_read_o && k < 20) begin step(1); k++; end
        check("t5_strobe_up", dmem_read_o, 1);
        step(2);
        #2;
        reset_ni = 1'b0;
        #1;
        check("t5_rst_read", dmem_read_o, 0);
        check("t5_rst_write", dmem_write_o, 0);
        check("t5_rst_resp", resp_valid_o, 0);
        check("t5_rst_ready", req_ready_o, 1);
        step(2);
        reset_ni = 1'b1;
        step(1);
        lat_cfg = 2;
        r0      = n_resp;
        send(0, 32'h48, 32'h0, 4'd9);
        drain();
        check("t5_after_resp", n_resp - r0, 1);
        check("t5_after_tag", last_resp_tag, 9);
        check("t5_after_data", last_resp_data, init_word(32'h48));

        // random stress
        lat_cfg = 0;
        r0      = n_resp;
        for (int i = 0; i < 2000; i++) begin
            w = ($urandom_range(0, 2) == 0);
            send(w, 32'h200 + 32'($urandom_range(0, 15) * 4), $urandom, 4'(i));
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
        end
        drain();
        check("t6_resp_count", n_resp - r0, 2000);
        check("t6_queue_empty", rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
